// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Data path width and common word constants.
    localparam int unsigned RegBusW  = 32;
    localparam logic [RegBusW-1:0] ZeroWord = '0;

    // Per-bit hold encoding on the stall vector.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Nested hold masks; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam logic [5:0] STALL_MASK_IF  = 6'b000011;
    localparam logic [5:0] STALL_MASK_ID  = 6'b000111;
    localparam logic [5:0] STALL_MASK_EX  = 6'b001111;
    localparam logic [5:0] STALL_MASK_MEM = 6'b011111;

    // Multi-cycle sequencer states.
    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_e;

    // OR of the masks of every active requester.
    function automatic logic [5:0] stall_mask(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
        logic [5:0] m;
        m = '0;
        if (req_if)  m = m | STALL_MASK_IF;
        if (req_id)  m = m | STALL_MASK_ID;
        if (req_ex)  m = m | STALL_MASK_EX;
        if (req_mem) m = m | STALL_MASK_MEM;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Sequencer for EX multi-cycle operations: holds EX for a programmed number of
// cycles, then signals completion, lingering in DONE while MEM is stalled.
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LEN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mc_req,
    input  logic [MC_LEN_W-1:0] mc_len,
    input  logic                flush_i,
    input  logic                hold_ex,
    output logic                ex_req,
    output logic                mc_busy,
    output logic                mc_done
);

    mc_state_e           state_q, state_d;
    logic [MC_LEN_W-1:0] cnt_q, cnt_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and EX request/status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_req  = 1'b0;
        mc_done = 1'b0;
        mc_busy = (state_q != MC_IDLE);
        unique case (state_q)
            MC_IDLE: begin
                ex_req = mc_req;
                if (mc_req) begin
                    state_d = MC_BUSY;
                    cnt_d   = mc_len;
                end
            end
            MC_BUSY: begin
                ex_req = 1'b1;
                // A zero length behaves like one busy cycle.
                if (cnt_q <= MC_LEN_W'(1)) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q - MC_LEN_W'(1);
                end
            end
            MC_DONE: begin
                mc_done = 1'b1;
                if (!hold_ex) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
        // Flush aborts any operation and discards a same-cycle request.
        if (flush_i) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: ORs the per-stage stall masks, runs the EX
// multi-cycle sequencer and gives MEM flushes priority over every stall.
// Optional stall-cycle performance counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LEN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                mc_req,
    input  logic [MC_LEN_W-1:0] mc_len,
    input  logic                flush_i,
    input  logic [31:0]         new_pc_i,
    output logic [5:0]          stall,
    output logic                flush_o,
    output logic [31:0]         new_pc_o,
    output logic                mc_busy,
    output logic                mc_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [31:0]         stall_cycles
`endif
);

    logic ex_req;
    logic seq_busy;
    logic seq_done;

    // MEM is the only requester whose mask covers EX, so it alone can hold DONE.
    pipe_ctrl_mc_seq #(
        .MC_LEN_W (MC_LEN_W)
    ) u_mc_seq (
        .clk     (clk),
        .rst     (rst),
        .mc_req  (mc_req),
        .mc_len  (mc_len),
        .flush_i (flush_i),
        .hold_ex (stallreq_mem),
        .ex_req  (ex_req),
        .mc_busy (seq_busy),
        .mc_done (seq_done)
    );

    // Output composition: reset forces zeros, flush overrides all stalls.
    always_comb begin
        stall    = '0;
        flush_o  = 1'b0;
        new_pc_o = ZeroWord;
        mc_busy  = 1'b0;
        mc_done  = 1'b0;
        if (!rst) begin
            mc_busy = seq_busy;
            if (flush_i) begin
                flush_o  = 1'b1;
                new_pc_o = new_pc_i;
            end else begin
                stall   = stall_mask(stallreq_if, stallreq_id, ex_req, stallreq_mem);
                mc_done = seq_done;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;

    // Saturating count of cycles with the PC held and no flush; clear wins.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles_q <= '0;
        end else if (stall[0] == Stop && !flush_o && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem;
    logic        mc_req;
    logic [5:0]  mc_len;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [5:0]  stall;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        mc_busy, mc_done;
`ifdef PIPE_CTRL_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state: remaining busy cycles and whether completion is pending.
    int m_busy_left;
    bit m_done;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_LEN_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .mc_req       (mc_req),
        .mc_len       (mc_len),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .stall        (stall),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic idle_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_mem = 0;
        mc_req = 0; mc_len = 0; flush_i = 0; new_pc_i = 0;
`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 0;
`endif
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        stallreq_mem = 1; flush_i = 1; new_pc_i = 32'h1234_5678; mc_req = 1;
        @(negedge clk);
        n_cmp++;
        if ({stall, flush_o, new_pc_o, mc_busy, mc_done} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_hold: got stall=%b flush=%b pc=%h busy=%b done=%b, want all 0",
                     stall, flush_o, new_pc_o, mc_busy, mc_done);
        end
        next_cycle();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({stall, flush_o, new_pc_o, mc_busy, mc_done} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_after: got stall=%b busy=%b done=%b, want 0", stall, mc_busy,
                     mc_done);
        end
        next_cycle();
    endtask

    task automatic test_single_stalls();
        logic [2:0]  req [4];
        logic [5:0]  exp [4];
        req[0] = 3'b100; exp[0] = 6'b000011;
        req[1] = 3'b010; exp[1] = 6'b000111;
        req[2] = 3'b001; exp[2] = 6'b011111;
        req[3] = 3'b011; exp[3] = 6'b011111;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            {stallreq_if, stallreq_id, stallreq_mem} = req[i];
            @(negedge clk);
            n_cmp++;
            if (stall !== exp[i]) begin
                n_err++;
                $display("FAIL single_stall[%0d]: got %b want %b", i, stall, exp[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_multicycle();
        int n;
        int lens [2];
        lens[0] = 4; lens[1] = 0;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            n = (lens[k] == 0) ? 1 : lens[k];
            for (int c = 0; c <= n + 2; c++) begin
                mc_req = (c == 0);
                mc_len = 6'(lens[k]);
                @(negedge clk);
                n_cmp++;
                if (stall !== ((c <= n) ? 6'b001111 : 6'b000000)) begin
                    n_err++;
                    $display("FAIL mc_stall len=%0d c=%0d: got %b", lens[k], c, stall);
                end
                n_cmp++;
                if (mc_done !== (c == n + 1)) begin
                    n_err++;
                    $display("FAIL mc_done len=%0d c=%0d: got %b want %b", lens[k], c,
                             mc_done, (c == n + 1));
                end
                n_cmp++;
                if (mc_busy !== (c >= 1 && c <= n + 1)) begin
                    n_err++;
                    $display("FAIL mc_busy len=%0d c=%0d: got %b", lens[k], c, mc_busy);
                end
                next_cycle();
            end
        end
        idle_inputs();
    endtask

    task automatic test_mem_during_done();
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            mc_req = (c == 0);
            mc_len = 6'd2;
            stallreq_mem = (c == 3 || c == 4);
            @(negedge clk);
            n_cmp++;
            if (mc_done !== (c >= 3 && c <= 5)) begin
                n_err++;
                $display("FAIL memdone_done c=%0d: got %b", c, mc_done);
            end
            n_cmp++;
            if (stall !== ((c <= 2) ? 6'b001111 : (c <= 4) ? 6'b011111 : 6'b000000)) begin
                n_err++;
                $display("FAIL memdone_stall c=%0d: got %b", c, stall);
            end
            n_cmp++;
            if (mc_busy !== (c >= 1 && c <= 5)) begin
                n_err++;
                $display("FAIL memdone_busy c=%0d: got %b", c, mc_busy);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_flush_busy();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            mc_req = (c == 0);
            mc_len = 6'd8;
            stallreq_id = (c == 2);
            flush_i = (c == 2);
            new_pc_i = (c == 2) ? 32'hBFC0_0380 : 32'h0;
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if (stall !== 6'd0 || flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0380) begin
                    n_err++;
                    $display("FAIL flush_cycle: got stall=%b flush=%b pc=%h want 0/1/bfc00380",
                             stall, flush_o, new_pc_o);
                end
            end else if (c > 2) begin
                n_cmp++;
                if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 6'd0 || flush_o !== 1'b0
                    || new_pc_o !== 32'd0) begin
                    n_err++;
                    $display("FAIL flush_after c=%0d: got done=%b busy=%b stall=%b flush=%b",
                             c, mc_done, mc_busy, stall, flush_o);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            mc_req = (c == 0);
            mc_len = 6'd6;
            rst = (c == 2 || c == 3);
            stallreq_id = (c == 2 || c == 3);
            @(negedge clk);
            if (c == 2 || c == 3) begin
                n_cmp++;
                if ({stall, flush_o, new_pc_o, mc_busy, mc_done} !== 41'd0) begin
                    n_err++;
                    $display("FAIL rstmid_hold c=%0d: got stall=%b busy=%b done=%b", c, stall,
                             mc_busy, mc_done);
                end
            end else if (c > 3) begin
                n_cmp++;
                if (mc_busy !== 1'b0 || mc_done !== 1'b0 || stall !== 6'd0) begin
                    n_err++;
                    $display("FAIL rstmid_after c=%0d: got busy=%b done=%b stall=%b", c,
                             mc_busy, mc_done, stall);
                end
            end
            next_cycle();
        end
        rst = 0;
        idle_inputs();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        stallreq_if = 1;
        for (int c = 0; c < 11; c++) begin
            flush_i = (c == 5);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_cycles !== 32'd10) begin
            n_err++;
            $display("FAIL perf_count: got %0d want 10", stall_cycles);
        end
        perf_clr = 1;
        stallreq_mem = 1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clr: got %0d want 0", stall_cycles);
        end
        next_cycle();
    endtask
`endif

    task automatic test_random();
        logic [5:0]  e_stall;
        logic        e_flush, e_busy, e_done, idle, exreq;
        logic [31:0] e_pc;
        int          len;
        do_reset();
        m_busy_left = 0;
        m_done = 0;
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            stallreq_if  = ($urandom_range(0, 99) < 15);
            stallreq_id  = ($urandom_range(0, 99) < 15);
            stallreq_mem = ($urandom_range(0, 99) < 20);
            mc_req       = ($urandom_range(0, 99) < 25);
            mc_len       = 6'($urandom_range(0, 5));
            flush_i      = ($urandom_range(0, 99) < 5);
            new_pc_i     = $urandom;
            @(negedge clk);
            idle  = (m_busy_left == 0) && !m_done;
            exreq = (idle && mc_req) || (m_busy_left > 0);
            e_stall = 6'd0;
            if (stallreq_if)  e_stall[1:0] = 2'b11;
            if (stallreq_id)  e_stall[2:0] = 3'b111;
            if (exreq)        e_stall[3:0] = 4'hF;
            if (stallreq_mem) e_stall[4:0] = 5'h1F;
            e_flush = flush_i;
            e_pc    = flush_i ? new_pc_i : 32'd0;
            e_busy  = !idle;
            e_done  = m_done && !flush_i;
            if (flush_i) e_stall = 6'd0;
            if (rst) begin
                e_stall = 0; e_flush = 0; e_pc = 0; e_busy = 0; e_done = 0;
            end
            n_cmp++;
            if (stall !== e_stall) begin
                n_err++;
                $display("FAIL rand_stall c=%0d: got %b want %b", c, stall, e_stall);
            end
            n_cmp++;
            if (flush_o !== e_flush || new_pc_o !== e_pc) begin
                n_err++;
                $display("FAIL rand_flush c=%0d: got %b/%h want %b/%h", c, flush_o, new_pc_o,
                         e_flush, e_pc);
            end
            n_cmp++;
            if (mc_busy !== e_busy || mc_done !== e_done) begin
                n_err++;
                $display("FAIL rand_mc c=%0d: got busy=%b done=%b want %b/%b", c, mc_busy,
                         mc_done, e_busy, e_done);
            end
            // Advance the model by one cycle.
            if (rst || flush_i) begin
                m_busy_left = 0;
                m_done = 0;
            end else if (idle && mc_req) begin
                len = int'(mc_len);
                m_busy_left = (len < 1) ? 1 : len;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_done = 1;
            end else if (m_done) begin
                m_done = stallreq_mem;
            end
            next_cycle();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_stalls();
        test_multicycle();
        test_mem_during_done();
        test_flush_busy();
        test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
